// File: rtl/msg_fifo_reader.sv
// Avalon-MM master that polls the image processor's message FIFO and decodes 3-word bounding-box messages.
// Optional MSG_READER_FLUSH_EN: on a rejected message, write the FIFO flush bit before re-polling.
module msg_fifo_reader #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned READ_LATENCY  = 1,
  parameter logic [31:0] MSG_ID        = 32'h0052_4242,
  parameter logic [2:0]  ADDR_STATUS   = 3'd0,
  parameter logic [2:0]  ADDR_MSG      = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        bb_valid,
  output logic [2:0]  bb_colour,
  output logic        bb_uncertain,
  output logic [10:0] bb_x_min,
  output logic [10:0] bb_y_min,
  output logic [10:0] bb_x_max,
  output logic [10:0] bb_y_max,
  output logic [15:0] msg_count,
  output logic [7:0]  sync_err_count,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_RD_STATUS   = 4'd1,
    S_WAIT_STATUS = 4'd2,
    S_POLL_WAIT   = 4'd3,
    S_RD_WORD     = 4'd4,
    S_WAIT_WORD   = 4'd5,
    S_CHECK       = 4'd6,
    S_EMIT        = 4'd7,
    S_ERR         = 4'd8
  } state_t;

  localparam logic [7:0]  LAT_LAST  = 8'(READ_LATENCY - 1);
  localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);

  state_t      r_state;
  logic [7:0]  r_lat;
  logic [15:0] r_poll;
  logic [1:0]  r_idx;
  logic [31:0] r_w1;
  logic [31:0] r_w2;
  logic        r_bb_valid;
  logic [2:0]  r_bb_colour;
  logic        r_bb_uncertain;
  logic [10:0] r_bb_x_min;
  logic [10:0] r_bb_y_min;
  logic [10:0] r_bb_x_max;
  logic [10:0] r_bb_y_max;
  logic [15:0] r_msg_count;
  logic [7:0]  r_err_count;

  state_t      w_state_nxt;
  logic [7:0]  w_lat_nxt;
  logic [15:0] w_poll_nxt;
  logic [1:0]  w_idx_nxt;
  logic        w_lat_done;
  logic        w_cap_w1;
  logic        w_cap_w2;
  logic        w_emit;
  logic        w_err;
  logic        w_rd;
  logic [2:0]  w_addr;
  logic        w_rsvd_bad;
`ifdef MSG_READER_FLUSH_EN
  logic        w_wr;
`endif

  // Bus protocol: each read is a single-cycle m_read pulse with m_address held for that cycle;
  // m_readdata is sampled READ_LATENCY cycles later, and the wait state guarantees a low gap
  // between reads because the slave pops on the rising edge of m_read.
  assign w_lat_done = (r_lat == LAT_LAST);
  assign w_rsvd_bad = r_w1[28] | (|r_w1[15:11]) | (|r_w2[31:27]) | (|r_w2[15:11]);

  always_comb begin
    w_state_nxt = r_state;
    w_lat_nxt   = '0;
    w_poll_nxt  = '0;
    w_idx_nxt   = r_idx;
    w_cap_w1    = 1'b0;
    w_cap_w2    = 1'b0;
    w_emit      = 1'b0;
    w_err       = 1'b0;
    w_rd        = 1'b0;
    w_addr      = ADDR_STATUS;
`ifdef MSG_READER_FLUSH_EN
    w_wr        = 1'b0;
`endif
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_RD_STATUS;
      end
      S_RD_STATUS: begin
        w_rd        = 1'b1;
        w_addr      = ADDR_STATUS;
        w_state_nxt = S_WAIT_STATUS;
      end
      S_WAIT_STATUS: begin
        if (!w_lat_done) begin
          w_lat_nxt = r_lat + 8'd1;
        end else if (m_readdata[15:8] >= 8'd3) begin
          w_idx_nxt   = 2'd0;
          w_state_nxt = S_RD_WORD;
        end else begin
          w_state_nxt = S_POLL_WAIT;
        end
      end
      S_POLL_WAIT: begin
        if (r_poll == POLL_LAST) w_state_nxt = S_IDLE;
        else                     w_poll_nxt  = r_poll + 16'd1;
      end
      S_RD_WORD: begin
        w_rd        = 1'b1;
        w_addr      = ADDR_MSG;
        w_state_nxt = S_WAIT_WORD;
      end
      S_WAIT_WORD: begin
        if (!w_lat_done) begin
          w_lat_nxt = r_lat + 8'd1;
        end else begin
          case (r_idx)
            2'd0: begin
              // A stale count after a software flush also lands here as a header mismatch.
              if (m_readdata != MSG_ID) begin
                w_state_nxt = S_ERR;
              end else begin
                w_idx_nxt   = 2'd1;
                w_state_nxt = S_RD_WORD;
              end
            end
            2'd1: begin
              w_cap_w1    = 1'b1;
              w_idx_nxt   = 2'd2;
              w_state_nxt = S_RD_WORD;
            end
            default: begin
              w_cap_w2    = 1'b1;
              w_state_nxt = S_CHECK;
            end
          endcase
        end
      end
      S_CHECK: begin
        w_state_nxt = w_rsvd_bad ? S_ERR : S_EMIT;
      end
      S_EMIT: begin
        w_emit      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ERR: begin
        w_err       = 1'b1;
`ifdef MSG_READER_FLUSH_EN
        w_wr        = 1'b1;
        w_addr      = ADDR_STATUS;
`endif
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_lat          <= '0;
      r_poll         <= '0;
      r_idx          <= '0;
      r_w1           <= '0;
      r_w2           <= '0;
      r_bb_valid     <= 1'b0;
      r_bb_colour    <= '0;
      r_bb_uncertain <= 1'b0;
      r_bb_x_min     <= '0;
      r_bb_y_min     <= '0;
      r_bb_x_max     <= '0;
      r_bb_y_max     <= '0;
      r_msg_count    <= '0;
      r_err_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat      <= w_lat_nxt;
      r_poll     <= w_poll_nxt;
      r_idx      <= w_idx_nxt;
      r_bb_valid <= w_emit;
      if (w_cap_w1) r_w1 <= m_readdata;
      if (w_cap_w2) r_w2 <= m_readdata;
      if (w_emit) begin
        r_bb_colour    <= r_w1[31:29];
        r_bb_uncertain <= r_w1[27];
        r_bb_x_min     <= r_w1[26:16];
        r_bb_y_min     <= r_w1[10:0];
        r_bb_x_max     <= r_w2[26:16];
        r_bb_y_max     <= r_w2[10:0];
        r_msg_count    <= r_msg_count + 16'd1;
      end
      if (w_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end

  assign m_read         = w_rd;
  assign m_address      = w_addr;
`ifdef MSG_READER_FLUSH_EN
  assign m_write        = w_wr;
  assign m_writedata    = w_wr ? 32'h0000_0010 : 32'h0;
`else
  assign m_write        = 1'b0;
  assign m_writedata    = 32'h0;
`endif
  assign m_chipselect   = m_read | m_write;
  assign bb_valid       = r_bb_valid;
  assign bb_colour      = r_bb_colour;
  assign bb_uncertain   = r_bb_uncertain;
  assign bb_x_min       = r_bb_x_min;
  assign bb_y_min       = r_bb_y_min;
  assign bb_x_max       = r_bb_x_max;
  assign bb_y_max       = r_bb_y_max;
  assign msg_count      = r_msg_count;
  assign sync_err_count = r_err_count;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_msg_fifo_reader.sv
// Bench for msg_fifo_reader: message-FIFO slave model, message decode model, per-cycle bus/output compare.
module tb_msg_fifo_reader;

  localparam int          POLL_INTERVAL = 16;
  localparam logic [31:0] MSG_ID        = 32'h0052_4242;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        bb_valid;
  logic [2:0]  bb_colour;
  logic        bb_uncertain;
  logic [10:0] bb_x_min, bb_y_min, bb_x_max, bb_y_max;
  logic [15:0] msg_count;
  logic [7:0]  sync_err_count;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  msg_fifo_reader #(
    .POLL_INTERVAL(POLL_INTERVAL), .READ_LATENCY(1), .MSG_ID(MSG_ID),
    .ADDR_STATUS(3'd0), .ADDR_MSG(3'd1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .m_chipselect(m_chipselect), .m_read(m_read), .m_write(m_write),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .bb_valid(bb_valid), .bb_colour(bb_colour), .bb_uncertain(bb_uncertain),
    .bb_x_min(bb_x_min), .bb_y_min(bb_y_min), .bb_x_max(bb_x_max), .bb_y_max(bb_y_max),
    .msg_count(msg_count), .sync_err_count(sync_err_count), .dbg_state(dbg_state)
  );

  // ---------------- model state ----------------
  logic [31:0] fifo_q[$];
  logic [47:0] exp_q[$];
  logic [3:0]  acc_q[$];
  int          acc_cyc[$];
  int          exp_err = 0;
  int          seen_valid = 0;
  int          cyc = 0;
  logic [47:0] last_box = '0;
  logic [15:0] model_cnt = '0;
  logic        prev_read = 1'b0;
  logic        prev_valid = 1'b0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_data = '0;
  int          lvl;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Box = {colour[3], uncertain, x_min, y_min, x_max, y_max}; top bit = message accepted.
  function automatic logic [48:0] decode(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2);
    logic ok;
    ok = (w0 == MSG_ID) && !w1[28] && (w1[15:11] == 5'd0) &&
         (w2[31:27] == 5'd0) && (w2[15:11] == 5'd0);
    return {ok, w1[31:29], w1[27], w1[26:16], w1[10:0], w2[26:16], w2[10:0]};
  endfunction

  function automatic logic [31:0] mk_w1(input logic [2:0] col, input logic unc,
                                        input logic [10:0] xmin, input logic [10:0] ymin);
    return {col, 1'b0, unc, xmin, 5'd0, ymin};
  endfunction

  function automatic logic [31:0] mk_w2(input logic [10:0] xmax, input logic [10:0] ymax);
    return {5'd0, xmax, 5'd0, ymax};
  endfunction

  // ---------------- slave: status + message FIFO, one cycle read latency ----------------
  always @(negedge clk) begin
    m_readdata = rd_pend ? rd_data : 32'hA5A5_A5A5;
    rd_pend = 1'b0;
    if (!reset && m_read) begin
      rd_pend = 1'b1;
      if (m_address == 3'd0) begin
        lvl = (fifo_q.size() > 255) ? 255 : fifo_q.size();
        rd_data = {16'h0, 8'(lvl), 8'h0};
      end else if (m_address == 3'd1) begin
        rd_data = (fifo_q.size() != 0) ? fifo_q.pop_front() : 32'h0;
      end else begin
        rd_data = 32'h0;
      end
    end
    if (!reset && m_write && m_address == 3'd0 && m_writedata[4]) fifo_q.delete();
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      check("rst_bus", {m_chipselect, m_read, m_write, m_address, m_writedata}, 64'd0);
      check("rst_bb", {bb_valid, bb_colour, bb_uncertain, bb_x_min, bb_y_min, bb_x_max, bb_y_max}, 64'd0);
      check("rst_cnt", {msg_count, sync_err_count}, 64'd0);
      last_box   = '0;
      model_cnt  = '0;
      prev_read  = 1'b0;
      prev_valid = 1'b0;
    end else begin
      check("chipselect", m_chipselect, m_read | m_write);
      check("read_gap", prev_read & m_read, 1'b0);
      check("valid_gap", prev_valid & bb_valid, 1'b0);
`ifdef MSG_READER_FLUSH_EN
      if (m_write) check("flush_write", {m_read, m_address, m_writedata}, {1'b0, 3'd0, 32'h10});
`else
      check("no_write", {m_write, m_writedata}, 64'd0);
`endif
      if (m_read || m_write) begin
        acc_q.push_back({m_write, m_address});
        acc_cyc.push_back(cyc);
      end
      if (bb_valid) begin
        seen_valid++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got pulse want none (t=%0t)", $time);
        end else begin
          last_box  = exp_q.pop_front();
          model_cnt = model_cnt + 16'd1;
          check("msg_count", msg_count, model_cnt);
        end
      end
      check("bb_hold", {bb_colour, bb_uncertain, bb_x_min, bb_y_min, bb_x_max, bb_y_max}, last_box);
      prev_read  = m_read;
      prev_valid = bb_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_msg(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [48:0] d;
    d = decode(w0, w1, w2);
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    if (d[48]) exp_q.push_back(d[47:0]);
    else if (exp_err < 255) exp_err++;
  endtask

  task automatic run_one(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    int sv0;
    logic [7:0] e0;
    int n;
    sv0 = seen_valid;
    e0  = sync_err_count;
    n   = 0;
    push_msg(w0, w1, w2);
    while (seen_valid == sv0 && sync_err_count == e0 && n < 300) begin
      tick(1);
      n++;
    end
    check("run_done", (seen_valid != sv0) || (sync_err_count != e0), 1'b1);
    tick(3);
    fifo_q.delete();
    check("err_count", sync_err_count, exp_err);
  endtask

  task automatic wait_acc(input int base, input logic [3:0] code, output int idx);
    int n;
    n = 0;
    idx = -1;
    while (idx < 0 && n < 300) begin
      for (int k = base; k < acc_q.size(); k++) begin
        if (acc_q[k] == code && idx < 0) idx = k;
      end
      if (idx < 0) begin
        tick(1);
        n++;
      end
    end
    check("acc_seen", idx >= 0, 1'b1);
  endtask

  function automatic int count_acc(input int base, input logic [3:0] code);
    int c;
    c = 0;
    for (int k = base; k < acc_q.size(); k++) if (acc_q[k] == code) c++;
    return c;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    logic [48:0] d;
    logic [2:0]  cols[4];
    int base, sv0, idx, ns, min_gap, last_c, n;

    cols[0] = 3'b001; cols[1] = 3'b010; cols[2] = 3'b100; cols[3] = 3'b000;
    reset = 1'b1;
    enable = 1'b0;
    m_readdata = '0;
    tick(3);
    check("reset_msg_count", msg_count, 16'd0);
    check("reset_err_count", sync_err_count, 8'd0);
    check("reset_valid", bb_valid, 1'b0);
    reset = 1'b0;
    tick(6);
    check("disabled_no_bus", acc_q.size(), 0);

    // pin the decode model against hand-derived fields
    d = decode(MSG_ID, 32'h20A0_0032, 32'h001E_0064);
    check("pin_ok", d[48], 1'b1);
    check("pin_colour", d[47:45], 3'b001);
    check("pin_unc", d[44], 1'b0);
    check("pin_xmin", d[43:33], 11'd160);
    check("pin_ymin", d[32:22], 11'd50);
    check("pin_xmax", d[21:11], 11'd30);
    check("pin_ymax", d[10:0], 11'd100);
    d = decode(32'h0052_4243, 32'h20A0_0032, 32'h001E_0064);
    check("pin_bad_hdr", d[48], 1'b0);
    d = decode(MSG_ID, 32'h30A0_0032, 32'h001E_0064);
    check("pin_rsvd", d[48], 1'b0);

    // basic good message
    enable = 1'b1;
    run_one(MSG_ID, 32'h20A0_0032, 32'h001E_0064);
    check("t1_colour", bb_colour, 3'b001);
    check("t1_unc", bb_uncertain, 1'b0);
    check("t1_xmin", bb_x_min, 11'd160);
    check("t1_ymin", bb_y_min, 11'd50);
    check("t1_xmax", bb_x_max, 11'd30);
    check("t1_ymax", bb_y_max, 11'd100);
    check("t1_count", msg_count, 16'd1);

    // only two words buffered: keep polling, never pop
    base = acc_q.size();
    fifo_q.push_back(MSG_ID);
    fifo_q.push_back(32'h20A0_0032);
    tick(90);
    check("cnt2_no_msg_reads", count_acc(base, 4'h1), 0);
    ns = 0;
    min_gap = 1000;
    last_c = -1;
    for (int k = base; k < acc_q.size(); k++) begin
      if (acc_q[k] == 4'h0) begin
        ns++;
        if (last_c >= 0 && (acc_cyc[k] - last_c) < min_gap) min_gap = acc_cyc[k] - last_c;
        last_c = acc_cyc[k];
      end
    end
    check("cnt2_polls", ns >= 3, 1'b1);
    check("cnt2_poll_gap", min_gap > POLL_INTERVAL, 1'b1);
    fifo_q.delete();
    tick(25);

    // bad header: one header read, error, then a status access (flush write first if built in)
    base = acc_q.size();
    sv0 = seen_valid;
    run_one(32'h0052_4243, 32'h20A0_0032, 32'h001E_0064);
    tick(30);
    check("hdr_err_count", sync_err_count, 8'd1);
    check("hdr_no_valid", seen_valid, sv0);
    check("hdr_one_pop", count_acc(base, 4'h1), 1);
    idx = -1;
    for (int k = base; k < acc_q.size(); k++) if (acc_q[k] == 4'h1 && idx < 0) idx = k;
`ifdef MSG_READER_FLUSH_EN
    check("hdr_then_flush", (idx >= 0 && idx + 1 < acc_q.size()) ? acc_q[idx+1] : 4'hF, 4'h8);
    check("hdr_then_status", (idx >= 0 && idx + 2 < acc_q.size()) ? acc_q[idx+2] : 4'hF, 4'h0);
`else
    check("hdr_then_status", (idx >= 0 && idx + 1 < acc_q.size()) ? acc_q[idx+1] : 4'hF, 4'h0);
`endif

    // reserved bits set: rejected, previous box held
    run_one(MSG_ID, 32'h30A0_0032, 32'h001E_0064);
    check("rsvd28_hold_xmin", bb_x_min, 11'd160);
    run_one(MSG_ID, 32'h20A0_0832, 32'h001E_0064);
    run_one(MSG_ID, 32'h20A0_0032, 32'h801E_0064);
    run_one(MSG_ID, 32'h20A0_0032, 32'h001E_8064);
    check("rsvd_err_count", sync_err_count, 8'd5);
    check("rsvd_msg_count", msg_count, 16'd1);

    // assorted good boxes, including field extremes
    run_one(MSG_ID, mk_w1(3'b100, 1'b1, 11'd2047, 11'd0), mk_w2(11'd1000, 11'd2047));
    check("ext_unc", bb_uncertain, 1'b1);
    check("ext_xmin", bb_x_min, 11'd2047);
    run_one(MSG_ID, mk_w1(3'b010, 1'b0, 11'd0, 11'd2047), mk_w2(11'd0, 11'd0));
    run_one(MSG_ID, mk_w1(3'b000, 1'b1, 11'd1, 11'd2), mk_w2(11'd3, 11'd4));
    check("ext_ymax", bb_y_max, 11'd4);

    // enable dropped mid-message: message still completes, then bus goes quiet
    tick(25);
    base = acc_q.size();
    sv0 = seen_valid;
    push_msg(MSG_ID, mk_w1(3'b001, 1'b1, 11'd10, 11'd20), mk_w2(11'd30, 11'd40));
    wait_acc(base, 4'h1, idx);
    enable = 1'b0;
    n = 0;
    while (seen_valid == sv0 && n < 100) begin
      tick(1);
      n++;
    end
    check("en_low_completes", seen_valid - sv0, 1);
    tick(3);
    base = acc_q.size();
    push_msg(MSG_ID, mk_w1(3'b010, 1'b0, 11'd11, 11'd21), mk_w2(11'd31, 11'd41));
    tick(60);
    check("en_low_quiet", acc_q.size() - base, 0);
    enable = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("en_high_resumes", exp_q.size(), 0);

    // long stream of good messages under the bus monitor
    sv0 = seen_valid;
    for (int i = 0; i < 1000; i++) begin
      push_msg(MSG_ID, mk_w1(cols[i % 4], 1'(i >> 1), 11'(i * 2), 11'(i + 7)),
               mk_w2(11'(2047 - i), 11'(i * 3)));
    end
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      tick(1);
      n++;
    end
    check("stream_drained", exp_q.size(), 0);
    check("stream_pulses", seen_valid - sv0, 1000);

    // asynchronous reset while a message word is in flight
    tick(25);
    base = acc_q.size();
    push_msg(MSG_ID, mk_w1(3'b100, 1'b0, 11'd5, 11'd6), mk_w2(11'd7, 11'd8));
    wait_acc(base, 4'h1, idx);
    reset = 1'b1;
    #1;
    check("async_rst_msg_count", msg_count, 16'd0);
    check("async_rst_err_count", sync_err_count, 8'd0);
    check("async_rst_xmin", bb_x_min, 11'd0);
    check("async_rst_bus", {m_read, m_chipselect}, 2'b00);
    exp_q.delete();
    fifo_q.delete();
    exp_err = 0;
    tick(3);
    reset = 1'b0;
    base = acc_q.size();
    sv0 = seen_valid;
    run_one(MSG_ID, mk_w1(3'b001, 1'b0, 11'd100, 11'd200), mk_w2(11'd300, 11'd400));
    check("post_rst_first_status", (acc_q.size() > base) ? acc_q[base] : 4'hF, 4'h0);
    check("post_rst_count", msg_count, 16'd1);

    // continuous bad headers saturate the error counter
    for (int i = 0; i < 262; i++) begin
      if (fifo_q.size() < 3) repeat (3) fifo_q.push_back(32'hFFFF_FFFF);
      lvl = fifo_q.size();
      n = 0;
      while (fifo_q.size() >= lvl && n < 100) begin
        tick(1);
        n++;
      end
      if (n >= 100) check("sat_progress", n, 0);
    end
    tick(10);
    fifo_q.delete();
    check("sat_err_count", sync_err_count, 8'd255);
    check("sat_msg_count", msg_count, 16'd1);

    tick(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
